// File: rtl/sram_bridge_if.sv
// AVR-side and SRAM-side signal bundle for the serial-address SRAM bridge.
// The bridge takes the slave view; the AVR/SRAM environment takes the master view.
interface sram_bridge_if #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 8
);
    logic                  avr_si;
    logic                  avr_sreg_en_n;
    logic                  avr_counter_n;
    logic                  avr_oe_n;
    logic                  avr_we_n;
    logic [DATA_WIDTH-1:0] avr_data_in;
    logic [DATA_WIDTH-1:0] avr_data_out;
    logic                  avr_data_oe;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_data_in;
    logic [DATA_WIDTH-1:0] sram_data_out;
    logic                  sram_data_oe;
    logic                  sram_ce_n;
    logic                  sram_oe_n;
    logic                  sram_we_n;

    modport slave (
        input  avr_si,
        input  avr_sreg_en_n,
        input  avr_counter_n,
        input  avr_oe_n,
        input  avr_we_n,
        input  avr_data_in,
        output avr_data_out,
        output avr_data_oe,
        output busy,
        output sram_addr,
        input  sram_data_in,
        output sram_data_out,
        output sram_data_oe,
        output sram_ce_n,
        output sram_oe_n,
        output sram_we_n
    );

    modport master (
        output avr_si,
        output avr_sreg_en_n,
        output avr_counter_n,
        output avr_oe_n,
        output avr_we_n,
        output avr_data_in,
        input  avr_data_out,
        input  avr_data_oe,
        input  busy,
        input  sram_addr,
        output sram_data_in,
        input  sram_data_out,
        input  sram_data_oe,
        input  sram_ce_n,
        input  sram_oe_n,
        input  sram_we_n
    );
endinterface

// File: rtl/sram_bridge.sv
// AVR-to-SRAM bridge: serial address shifter, auto-increment counter and
// strobe-generating access FSM with programmable wait states.
module sram_bridge #(
    parameter int ADDR_WIDTH  = 21,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 1,
    parameter int MSB_FIRST   = 1
) (
    input logic          clk,
    input logic          reset,
    sram_bridge_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        END
    } state_t;

    state_t     state;
    logic       is_wr;
    logic [3:0] cnt;
    logic       oe_q;
    logic       we_q;
    logic       oe_arm;
    logic       we_arm;
    logic       rd_edge;
    logic       wr_edge;

    // A request line must be seen high after reset before its fall counts,
    // so a level held low across reset cannot start an access.
    always_comb begin
        rd_edge = oe_arm & oe_q & ~bus.avr_oe_n;
        wr_edge = we_arm & we_q & ~bus.avr_we_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            is_wr             <= 1'b0;
            cnt               <= '0;
            oe_q              <= 1'b1;
            we_q              <= 1'b1;
            oe_arm            <= 1'b0;
            we_arm            <= 1'b0;
            bus.sram_addr     <= '0;
            bus.avr_data_out  <= '0;
            bus.sram_data_out <= '0;
            bus.sram_ce_n     <= 1'b1;
            bus.sram_oe_n     <= 1'b1;
            bus.sram_we_n     <= 1'b1;
            bus.sram_data_oe  <= 1'b0;
            bus.avr_data_oe   <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            oe_q <= bus.avr_oe_n;
            we_q <= bus.avr_we_n;
            if (bus.avr_oe_n) oe_arm <= 1'b1;
            if (bus.avr_we_n) we_arm <= 1'b1;
            if (bus.avr_data_oe && bus.avr_oe_n)
                bus.avr_data_oe <= 1'b0;

            case (state)
                IDLE: begin
                    if (wr_edge) begin
                        state             <= ACCESS;
                        is_wr             <= 1'b1;
                        cnt               <= 4'(WAIT_STATES);
                        bus.sram_data_out <= bus.avr_data_in;
                        bus.sram_ce_n     <= 1'b0;
                        bus.sram_we_n     <= 1'b0;
                        bus.sram_data_oe  <= 1'b1;
                        bus.busy          <= 1'b1;
                    end else if (rd_edge) begin
                        state         <= ACCESS;
                        is_wr         <= 1'b0;
                        cnt           <= 4'(WAIT_STATES);
                        bus.sram_ce_n <= 1'b0;
                        bus.sram_oe_n <= 1'b0;
                        bus.busy      <= 1'b1;
                    end else if (!bus.avr_sreg_en_n) begin
                        if (MSB_FIRST != 0)
                            bus.sram_addr <= {bus.sram_addr[ADDR_WIDTH-2:0],
                                              bus.avr_si};
                        else
                            bus.sram_addr <= {bus.avr_si,
                                              bus.sram_addr[ADDR_WIDTH-1:1]};
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state         <= END;
                        bus.sram_ce_n <= 1'b1;
                        bus.sram_oe_n <= 1'b1;
                        bus.sram_we_n <= 1'b1;
                        if (!is_wr) begin
                            bus.avr_data_out <= bus.sram_data_in;
                            bus.avr_data_oe  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                END: begin
                    state            <= IDLE;
                    bus.busy         <= 1'b0;
                    bus.sram_data_oe <= 1'b0;
                    if (!bus.avr_counter_n)
                        bus.sram_addr <= bus.sram_addr + ADDR_WIDTH'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_bridge.sv
// Scoreboard bench for sram_bridge: stimulus queues expected accesses,
// a monitor measures each strobe/busy window and compares on completion.
module tb_sram_bridge;
    localparam int AW = 21;
    localparam int DW = 8;
    localparam int WS = 2;

    typedef struct {
        bit          wr;
        logic [20:0] addr;
        logic [7:0]  data;
        int          strobe_len;
        int          busy_len;
        int          doe_len;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    bit   done = 1'b0;
    txn_t exp_q[$];

    int          cel;
    int          bl;
    int          dl;
    bit          o_wr;
    logic [20:0] o_addr;
    logic [7:0]  o_data;
    txn_t        e;

    sram_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b ();

    sram_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_STATES(WS),
        .MSB_FIRST  (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (b.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        else
            n_pass++;
    endtask

    task automatic shift_addr(input logic [20:0] v);
        for (int i = 20; i >= 0; i--) begin
            b.avr_si        = v[i];
            b.avr_sreg_en_n = 1'b0;
            tick(1);
        end
        b.avr_sreg_en_n = 1'b1;
        b.avr_si        = 1'b0;
    endtask

    task automatic expect_txn(input bit wr, input logic [20:0] a,
                              input logic [7:0] d);
        txn_t t;
        t.wr         = wr;
        t.addr       = a;
        t.data       = d;
        t.strobe_len = WS + 1;
        t.busy_len   = WS + 2;
        t.doe_len    = wr ? WS + 2 : 0;
        exp_q.push_back(t);
    endtask

    initial begin
        b.avr_si        = 1'b0;
        b.avr_sreg_en_n = 1'b1;
        b.avr_counter_n = 1'b1;
        b.avr_oe_n      = 1'b1;
        b.avr_we_n      = 1'b1;
        b.avr_data_in   = '0;
        b.sram_data_in  = '0;
        cel = 0;
        bl  = 0;
        dl  = 0;
        o_wr   = 1'b0;
        o_addr = '0;
        o_data = '0;
        fork
            begin
                tick(3);
                chk("rst_addr", 32'(b.sram_addr), 0);
                chk("rst_ce_n", 32'(b.sram_ce_n), 1);
                chk("rst_oe_n", 32'(b.sram_oe_n), 1);
                chk("rst_we_n", 32'(b.sram_we_n), 1);
                chk("rst_busy", 32'(b.busy), 0);
                chk("rst_doe", 32'(b.sram_data_oe), 0);
                chk("rst_avr_oe", 32'(b.avr_data_oe), 0);
                chk("rst_dout", 32'(b.avr_data_out), 0);
                reset = 1'b0;
                tick(2);

                shift_addr(21'h1ABCDE);
                chk("shift_addr", 32'(b.sram_addr), 32'h1ABCDE);

                b.sram_data_in = 8'h5A;
                expect_txn(1'b0, 21'h1ABCDE, 8'h5A);
                b.avr_oe_n = 1'b0;
                tick(8);
                chk("rd_avr_oe_held", 32'(b.avr_data_oe), 1);
                chk("rd_dout", 32'(b.avr_data_out), 32'h5A);
                chk("rd_addr_kept", 32'(b.sram_addr), 32'h1ABCDE);
                b.avr_oe_n = 1'b1;
                tick(1);
                chk("rd_avr_oe_drop", 32'(b.avr_data_oe), 0);
                tick(2);

                shift_addr(21'h000010);
                b.avr_counter_n = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    b.avr_data_in = 8'(8'h11 * (k + 1));
                    expect_txn(1'b1, 21'(21'h10 + k), b.avr_data_in);
                    b.avr_we_n = 1'b0;
                    tick(1);
                    b.avr_we_n = 1'b1;
                    tick(6);
                end
                chk("burst_addr", 32'(b.sram_addr), 32'h14);
                chk("burst_avr_oe", 32'(b.avr_data_oe), 0);

                shift_addr(21'h1FFFFF);
                b.sram_data_in = 8'hC3;
                expect_txn(1'b0, 21'h1FFFFF, 8'hC3);
                b.avr_oe_n = 1'b0;
                tick(1);
                b.avr_oe_n = 1'b1;
                tick(6);
                chk("wrap_addr", 32'(b.sram_addr), 0);
                b.avr_counter_n = 1'b1;

                shift_addr(21'h0000A5);
                b.avr_data_in = 8'h77;
                expect_txn(1'b1, 21'h0000A5, 8'h77);
                b.avr_oe_n = 1'b0;
                b.avr_we_n = 1'b0;
                tick(1);
                b.avr_si        = 1'b1;
                b.avr_sreg_en_n = 1'b0;
                tick(3);
                b.avr_sreg_en_n = 1'b1;
                b.avr_si        = 1'b0;
                b.avr_oe_n      = 1'b1;
                b.avr_we_n      = 1'b1;
                tick(5);
                chk("coll_addr", 32'(b.sram_addr), 32'hA5);
                chk("coll_avr_oe", 32'(b.avr_data_oe), 0);

                b.avr_data_in = 8'h99;
                b.avr_we_n    = 1'b0;
                tick(2);
                chk("abort_in_access", 32'(b.sram_we_n), 0);
                reset = 1'b1;
                tick(1);
                chk("abort_ce_n", 32'(b.sram_ce_n), 1);
                chk("abort_we_n", 32'(b.sram_we_n), 1);
                chk("abort_busy", 32'(b.busy), 0);
                chk("abort_addr", 32'(b.sram_addr), 0);
                reset = 1'b0;
                tick(8);
                chk("held_we_busy", 32'(b.busy), 0);
                chk("held_we_ce_n", 32'(b.sram_ce_n), 1);
                b.avr_we_n = 1'b1;
                tick(3);
                chk("queue_drained", 32'(exp_q.size()), 0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (reset) begin
                        cel = 0;
                        bl  = 0;
                        dl  = 0;
                    end else begin
                        if (!b.sram_ce_n) begin
                            cel++;
                            o_wr   = !b.sram_we_n;
                            o_addr = b.sram_addr;
                            if (!b.sram_we_n) o_data = b.sram_data_out;
                        end
                        if (b.sram_data_oe) dl++;
                        if (b.busy) begin
                            bl++;
                        end else if (bl > 0) begin
                            if (!o_wr) o_data = b.avr_data_out;
                            if (exp_q.size() == 0) begin
                                n_total++;
                                $display("FAIL unexpected_access: addr 0x%0h, expected none",
                                         o_addr);
                            end else begin
                                e = exp_q.pop_front();
                                chk("txn_wr", 32'(o_wr), 32'(e.wr));
                                chk("txn_addr", 32'(o_addr), 32'(e.addr));
                                chk("txn_data", 32'(o_data), 32'(e.data));
                                chk("txn_strobe_len", cel, e.strobe_len);
                                chk("txn_busy_len", bl, e.busy_len);
                                chk("txn_doe_len", dl, e.doe_len);
                            end
                            cel = 0;
                            bl  = 0;
                            dl  = 0;
                        end
                    end
                end
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
Parametrised successor of the CPLD AVR-to-SRAM glue. It combines the serial address shift register, the auto-increment counter and the bus access state machine into one registered block on a single clock. Unlike the current design, it generates SRAM strobes itself with programmable wait states. It also handles configurable address and data widths, selectable shift direction, and an explicit busy handshake back to the AVR.

Parameters:
ADDR_WIDTH, 21, SRAM address width in bits (>=2)
DATA_WIDTH, 8, data bus width in bits
WAIT_STATES, 1, extra cycles the SRAM strobe is held low (0..15)
MSB_FIRST, 1, 1 = serial address shifted in MSB first, 0 = LSB first

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
avr_si  in  1  serial address bit
avr_sreg_en_n  in  1  active-low shift enable
avr_counter_n  in  1  active-low auto-increment enable
avr_oe_n  in  1  active-low read request (level)
avr_we_n  in  1  active-low write request (level)
avr_data_in  in  DATA_WIDTH  write data from AVR
avr_data_out  out  DATA_WIDTH  registered read data to AVR
avr_data_oe  out  1  AVR bus drive enable
busy  out  1  access in progress
sram_addr  out  ADDR_WIDTH  registered address
sram_data_in  in  DATA_WIDTH  data from SRAM
sram_data_out  out  DATA_WIDTH  data to SRAM
sram_data_oe  out  1  SRAM bus drive enable
sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active low, registered

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high (`reset`).
- Reset values: sram_addr=0, avr_data_out=0, all strobes=1, sram_data_oe=0, avr_data_oe=0, busy=0, state=IDLE, request-edge registers=1.
- Reset asserted mid-access aborts the access. Strobes go high at the next rising edge, and no address increment occurs.
- Request detection: avr_oe_n and avr_we_n are registered once.
  - A start event is the previous value 1 and the current value 0 (falling edge).
  - Level-low requests held across reset do not start an access.
- FSM states: IDLE, ACCESS, END.
- IDLE:
  - A write edge latches avr_data_in into sram_data_out, then moves to ACCESS (write).
  - A read edge moves to ACCESS (read).
  - If both edges occur in the same cycle, the write wins and the read is dropped.
  - Edges that occur while not in IDLE are ignored.
- ACCESS:
  - sram_ce_n=0; sram_oe_n=0 (read) or sram_we_n=0 (write).
  - sram_data_oe=1 for writes.
  - The state lasts exactly WAIT_STATES+1 cycles, counted by an internal down-counter.
  - Read: avr_data_out captures sram_data_in on the last ACCESS cycle.
- END (1 cycle):
  - All strobes return to 1.
  - For writes, sram_data_oe stays 1 for this hold cycle, then drops to 0.
  - If avr_counter_n==0, sram_addr increments by 1. All-ones wraps to 0.
  - Then returns to IDLE.
- busy: 1 from the cycle after the edge is detected (first ACCESS cycle) through END inclusive, 0 in IDLE.
- Access latency: edge registered at cycle N, ACCESS starts N+1, END at N+2+WAIT_STATES, busy=0 at N+3+WAIT_STATES.
- avr_data_oe: set at END of a read. Stays 1 while avr_oe_n==0 and clears the cycle after avr_oe_n rises. Always 0 for writes.
- Shift register:
  - Only in IDLE with avr_sreg_en_n==0, one bit per clk.
  - MSB_FIRST=1: addr <= {addr[W-2:0], avr_si}; otherwise addr <= {avr_si, addr[W-1:1]}.
  - Shift requests while busy are ignored; the address is never corrupted mid-access.
- Priority in IDLE for the same cycle: an access start beats a shift. The shift bit is dropped.

Test Plan:
- Shift load: ADDR_WIDTH=21, MSB_FIRST=1, shift 21 bits of 0x1ABCDE -> sram_addr==0x1ABCDE, strobes stay high throughout.
- Read with wait states: WAIT_STATES=2, sram_data_in=0x5A, pull avr_oe_n low -> sram_ce_n/sram_oe_n low for exactly 3 cycles, avr_data_out==0x5A, busy high 4 cycles, avr_data_oe=1 until avr_oe_n rises.
- Write burst with counter: avr_counter_n=0, start addr 0x000010, four write pulses 0x11..0x44 -> each sram_we_n pulse is WAIT_STATES+1 cycles, with data and address matching. Final sram_addr==0x000014.
- Counter wrap: sram_addr=0x1FFFFF, counter enabled, one read -> sram_addr==0x000000 after END.
- Collision: assert both request edges in the same cycle, plus a shift attempt during busy -> only a write is performed, and sram_addr is unchanged by the shift.
- Reset mid-access: assert reset during an ACCESS cycle -> next edge has all strobes=1, busy=0, sram_addr=0. A held-low avr_we_n does not retrigger after reset.
